// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment driver: shadowed digit load, hex decode, leading-zero
// blanking, one blank cycle per digit change, frame-done pulse.
module seg_scan_driver #(
  parameter int NUM_DIGITS    = 4,
  parameter int PRESCALE      = 100000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic                    load_ack,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);
  localparam int PW = $clog2(PRESCALE);
  localparam int IW = $clog2(NUM_DIGITS);

  logic [PW-1:0]                  pcnt_q, pcnt_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]     pend_dig_q, act_dig_q;
  logic [NUM_DIGITS-1:0]          pend_dp_q, act_dp_q;
  logic [6:0]                     seg_q, seg_d;
  logic                           dp_q, dp_d;
  logic [NUM_DIGITS-1:0]          an_q, an_d;
  logic                           ack_q, fdone_q;
  logic                           wrap, last, frame_end;
  logic [NUM_DIGITS-1:0]          blank;
  logic                           run;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  assign wrap      = (pcnt_q == PW'(PRESCALE-1));
  assign last      = (idx_q == IW'(NUM_DIGITS-1));
  assign frame_end = wrap && last;

  always_comb begin
    pcnt_d = wrap ? '0 : pcnt_q + 1'b1;
    idx_d  = idx_q;
    if (wrap) idx_d = last ? '0 : idx_q + 1'b1;
  end

  // A digit is leading-blank when it and everything above it are zero.
  always_comb begin
    blank = '0;
    run   = 1'b1;
    for (int i = NUM_DIGITS-1; i >= 0; i--) begin
      run = run & (act_dig_q[i] == 4'd0);
      if (BLANK_LEADING != 0 && i > 0) blank[i] = run;
    end
  end

  // Anode is computed from next-state so it lines up with pcnt_q when visible.
  always_comb begin
    seg_d = blank[idx_q] ? 7'h7F : hex7(act_dig_q[idx_q]);
    dp_d  = blank[idx_q] ? 1'b1  : ~act_dp_q[idx_q];
    an_d  = '1;
    if (pcnt_d != '0) an_d[idx_d] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q     <= '0;
      idx_q      <= '0;
      pend_dig_q <= '0;
      pend_dp_q  <= '0;
      act_dig_q  <= '0;
      act_dp_q   <= '0;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
      an_q       <= '1;
      ack_q      <= 1'b0;
      fdone_q    <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      ack_q   <= load;
      fdone_q <= frame_end;
      if (load) begin
        pend_dig_q <= digits_in;
        pend_dp_q  <= dp_in;
      end
      // Old pending wins on a colliding load: nonblocking read of pend_*_q.
      if (frame_end) begin
        act_dig_q <= pend_dig_q;
        act_dp_q  <= pend_dp_q;
      end
    end
  end

  assign seg_n      = seg_q;
  assign dp_n       = dp_q;
  assign an_n       = an_q;
  assign load_ack   = ack_q;
  assign frame_done = fdone_q;
endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Downstream display stage of the 7-segment path.
- Takes packed 4-bit digit codes from the value-mapping logic and latches them into a shadow register with a load handshake.
- Time-multiplexes the digits onto one shared active-low segment bus and active-low digit anodes.
- Provides hex decode, leading-zero blanking, an anti-ghosting blank slot on every digit change, and a frame-done pulse.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; legal range 2..8.
- PRESCALE, 100000: clk cycles each digit is held; minimum 4.
- BLANK_LEADING, 1: 1 blanks leading zero digits; 0 shows all digits.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- digits_in  input  4*NUM_DIGITS  packed digit codes; [3:0] is digit 0 (least significant).
- dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
- load  input  1  pulse: capture digits_in/dp_in into the pending register.
- load_ack  output  1  one-cycle pulse, the cycle after load is sampled.
- seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_n  output  1  decimal point, active-low.
- an_n  output  NUM_DIGITS  digit enables, active-low; at most one bit low at any time.
- frame_done  output  1  one-cycle pulse when the last digit's slot ends.

Behaviour:
- Reset (async assert, sync release):
  - prescale counter = 0, digit index = 0.
  - pending and active registers = 0, all dp = 0.
  - seg_n = 7'h7F, dp_n = 1, an_n = all 1s, load_ack = 0, frame_done = 0.
- Prescaler:
  - pcnt counts 0..PRESCALE-1 and wraps.
  - On wrap (pcnt == PRESCALE-1), idx advances; idx == NUM_DIGITS-1 wraps to 0.
- Anti-ghost slot:
  - While pcnt == 0, an_n = all 1s. This gives one blank cycle per digit change.
  - For pcnt 1..PRESCALE-1, an_n[idx] = 0 and all other bits = 1.
- Frame boundary: the cycle where pcnt == PRESCALE-1 and idx == NUM_DIGITS-1.
  - frame_done = 1 in the following cycle.
  - active <= pending on the same edge.
- Load:
  - On a rising clk edge with load = 1, pending <= {dp_in, digits_in}.
  - load_ack = 1 on the next cycle.
  - Back-to-back loads: the last one wins; each load produces its own ack.
  - Display never tears: new values become visible only from the first digit slot of the next frame.
- Load coinciding with frame boundary:
  - active takes the pre-load pending value.
  - The new value shows one frame later.
- Decode:
  - Standard hex 0..F onto {g..a}, active-low.
  - Values: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Leading-zero blanking (BLANK_LEADING=1):
  - Digit i>0 is blanked if it and every more-significant digit are 0.
  - Digit 0 is never blanked.
  - Blanked digit: seg_n = 7F and dp_n = 1, but its anode still scans so timing stays uniform.
  - A digit with dp set is still blanked if zero and leading. Its dp does not stop blanking.
- Outputs:
  - seg_n, dp_n and an_n are registered.
  - seg_n/dp_n reflect the digit selected by the current idx, one cycle after idx changes. They update during the blank slot, so they are stable when the anode enables.
- Mid-operation reset returns to the reset state immediately, asynchronously to clk. Scanning restarts at digit 0.

Test Plan:
- Reset: hold rst_n=0 → an_n=4'hF, seg_n=7F, dp_n=1. Release → first an_n=4'hE appears at pcnt=1 (PRESCALE=4, NUM_DIGITS=4).
- Scan order: pulse load with digits_in=16'h1234, wait one frame → an_n cycles E,D,B,7, each low 3 cycles with a 1-cycle all-F gap. seg_n = 19,30,24,79 per digit (digit 0 = 4).
- Handshake and tearing: load 16'h1234, then load 16'h5678 mid-frame → load_ack pulses once per load. Display keeps 1234 until frame_done, then shows 5678 from the next digit-0 slot.
- Blanking: load 16'h0070 → digits 3 and 2 show 7F, digit 1 shows 78, digit 0 shows 40. Load 16'h0000 → only digit 0 shows 40. With BLANK_LEADING=0 → all show 40.
- Decimal point: dp_in=4'b0010, digits 16'h0012 → dp_n=0 only while an_n=4'hD. dp_in=4'b1000 on blanked digit 3 → dp_n stays 1.
- Boundary collision: assert load exactly at the frame-boundary cycle → active keeps the previous pending value for the next frame. The new value appears after the following frame_done. Assert rst_n=0 mid-slot → an_n=F within the same cycle.
